// File: rtl/mult_iter_pkg.sv
// rtl/mult_iter_pkg.sv - shared constants and FSM encoding for the iterative multiplier
package mult_iter_pkg;

  // Width of one operand limb fed to the 16x16 core multiplier
  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mult_iter_mult16.sv
// rtl/mult_iter_mult16.sv - 16x16 unsigned combinational multiplier core
module mult16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);

  // Full 32-bit product; both operands are zero-extended before multiplying
  assign p_o = 32'(a_i) * 32'(b_i);

endmodule

// File: rtl/mult_iter.sv
// rtl/mult_iter.sv - iterative limb-by-limb signed/unsigned multiplier
module mult_iter
  import mult_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dataa,
  input  logic [WIDTH-1:0]     datab,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int LIMBS  = WIDTH / LIMB_W;
  localparam int STEPS  = LIMBS * LIMBS;
  localparam int ACC_W  = 2 * WIDTH;
  localparam int STEP_W = $clog2(STEPS + 1);
  localparam int IDX_W  = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [IDX_W-1:0]   ai_q, ai_d;
  logic [IDX_W-1:0]   bj_q, bj_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;

  logic [LIMB_W-1:0]  a_limb;
  logic [LIMB_W-1:0]  b_limb;
  logic [2*LIMB_W-1:0] part_prod;
  logic [ACC_W-1:0]   part_shifted;
  logic               last_step;
  logic               last_ai;

  // Select the current a-limb (i = step mod LIMBS) and b-limb (j = step div LIMBS)
  always_comb begin
    a_limb       = LIMB_W'(a_q >> (int'(ai_q) * LIMB_W));
    b_limb       = LIMB_W'(b_q >> (int'(bj_q) * LIMB_W));
    part_shifted = ACC_W'(part_prod) << ((int'(ai_q) + int'(bj_q)) * LIMB_W);
    last_step    = (step_q == STEP_W'(STEPS - 1));
    last_ai      = (ai_q == IDX_W'(LIMBS - 1));
  end

  mult16 u_mult16 (
    .a_i (a_limb),
    .b_i (b_limb),
    .p_o (part_prod)
  );

  // Next-state logic: accept, accumulate one partial product per cycle, sign-fix, hand off
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    step_d      = step_q;
    ai_d        = ai_q;
    bj_d        = bj_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Negating the most negative value wraps to the same bit pattern,
          // which read as unsigned is exactly its magnitude
          a_d     = (is_signed && dataa[WIDTH-1]) ? -dataa : dataa;
          b_d     = (is_signed && datab[WIDTH-1]) ? -datab : datab;
          neg_d   = is_signed & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
          acc_d   = '0;
          step_d  = '0;
          ai_d    = '0;
          bj_d    = '0;
          state_d = ST_MUL;
        end
      end

      ST_MUL: begin
        acc_d  = acc_q + part_shifted;
        step_d = step_q + STEP_W'(1);
        if (last_ai) begin
          ai_d = '0;
          bj_d = bj_q + IDX_W'(1);
        end else begin
          ai_d = ai_q + IDX_W'(1);
        end
        if (last_step) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        result_d    = neg_q ? -acc_q : acc_q;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      step_q      <= '0;
      ai_q        <= '0;
      bj_q        <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      ai_q        <= ai_d;
      bj_q        <= bj_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mult_iter.sv
// tb/tb_mult_iter.sv - directed-vector bench for mult_iter at WIDTH 32 and 64
module tb_mult_iter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic        v32_in_valid = 1'b0;
  logic        v32_in_ready;
  logic        v32_is_signed = 1'b0;
  logic [31:0] v32_dataa = '0;
  logic [31:0] v32_datab = '0;
  logic        v32_out_valid;
  logic        v32_out_ready = 1'b0;
  logic [63:0] v32_result;

  logic         v64_in_valid = 1'b0;
  logic         v64_in_ready;
  logic         v64_is_signed = 1'b0;
  logic [63:0]  v64_dataa = '0;
  logic [63:0]  v64_datab = '0;
  logic         v64_out_valid;
  logic         v64_out_ready = 1'b0;
  logic [127:0] v64_result;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(32)) u_dut32 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (v32_in_valid),
    .in_ready  (v32_in_ready),
    .is_signed (v32_is_signed),
    .dataa     (v32_dataa),
    .datab     (v32_datab),
    .out_valid (v32_out_valid),
    .out_ready (v32_out_ready),
    .result    (v32_result)
  );

  mult_iter #(.WIDTH(64)) u_dut64 (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (v64_in_valid),
    .in_ready  (v64_in_ready),
    .is_signed (v64_is_signed),
    .dataa     (v64_dataa),
    .datab     (v64_datab),
    .out_valid (v64_out_valid),
    .out_ready (v64_out_ready),
    .result    (v64_result)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int stall);
    int lat;
    @(negedge clk);
    v32_is_signed = sgn;
    v32_dataa     = a;
    v32_datab     = b;
    v32_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    v32_in_valid  = 1'b0;
    v32_dataa     = ~a;
    v32_datab     = a ^ b;
    v32_is_signed = ~sgn;
    check({tag, "_busy"}, 128'(v32_in_ready), 128'(0));
    lat = 0;
    while (!v32_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(5));
    check({tag, "_res"}, 128'(v32_result), 128'(exp));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      v32_in_valid  = 1'b1;
      v32_is_signed = 1'b0;
      v32_dataa     = 32'h0000_0007;
      v32_datab     = 32'h0000_0009;
      @(posedge clk);
      #1;
      check({tag, "_stall_res"}, 128'(v32_result), 128'(exp));
      check({tag, "_stall_rdy"}, 128'({v32_in_ready, v32_out_valid}), 128'(2'b01));
    end
    @(negedge clk);
    v32_in_valid  = 1'b0;
    v32_out_ready = 1'b1;
    @(posedge clk);
    #1;
    v32_out_ready = 1'b0;
    check({tag, "_handoff"}, 128'({v32_in_ready, v32_out_valid}), 128'(2'b10));
  endtask

  task automatic run64(input string tag, input logic sgn, input logic [63:0] a,
                       input logic [63:0] b, input logic [127:0] exp);
    int lat;
    @(negedge clk);
    v64_is_signed = sgn;
    v64_dataa     = a;
    v64_datab     = b;
    v64_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    v64_in_valid  = 1'b0;
    v64_dataa     = b;
    v64_datab     = ~a;
    lat = 0;
    while (!v64_out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 128'(lat), 128'(17));
    check({tag, "_res"}, v64_result, exp);
    @(negedge clk);
    v64_out_ready = 1'b1;
    @(posedge clk);
    #1;
    v64_out_ready = 1'b0;
    check({tag, "_handoff"}, 128'(v64_out_valid), 128'(0));
  endtask

  function automatic logic [127:0] ref64(input logic sgn, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    if (sgn) begin
      sa = $signed({{64{a[63]}}, a});
      sb = $signed({{64{b[63]}}, b});
    end else begin
      sa = $signed({64'b0, a});
      sb = $signed({64'b0, b});
    end
    return 128'(sa * sb);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    int seen;

    #2;
    check("rst_in_ready", 128'({v32_in_ready, v64_in_ready}), 128'(2'b11));
    check("rst_out_valid", 128'({v32_out_valid, v64_out_valid}), 128'(0));
    check("rst_result", 128'(v32_result) | v64_result, 128'(0));
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;

    run32("u_ones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    run32("s_m3x5", 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 0);
    run32("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    run32("u_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
    run32("s_zero", 1'b1, 32'h0000_0000, 32'h8000_0000, 64'h0, 0);
    run32("u_stall", 1'b0, 32'h0001_0000, 32'h0003_0002, 64'h0000_0003_0002_0000, 10);
    run32("s_after", 1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001, 0);

    // Abort during MUL step 2
    @(negedge clk);
    v32_is_signed = 1'b0;
    v32_dataa     = 32'hFFFF_FFFF;
    v32_datab     = 32'h1234_5678;
    v32_in_valid  = 1'b1;
    @(posedge clk);
    #1;
    v32_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_in_ready", 128'(v32_in_ready), 128'(1));
    check("abort_out_valid", 128'(v32_out_valid), 128'(0));
    check("abort_result", 128'(v32_result), 128'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (v32_out_valid) seen++;
    end
    check("abort_no_result", 128'(seen), 128'(0));
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    run32("post_rst", 1'b0, 32'h0000_1234, 32'h0000_5678, 64'h0000_0000_0626_0060, 0);

    run64("w64_smin", 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          128'h4000_0000_0000_0000_0000_0000_0000_0000);
    run64("w64_uones", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run64("w64_sm1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'h1);
    run64("w64_smix", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0003,
          128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
    for (int k = 0; k < 8; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run64($sformatf("w64_rnd%0d", k), k[0], ra, rb, ref64(k[0], ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mult_iter.md
MULT_ITER -- requirements
Module: mult_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values 16, 32, 48, 64 (multiple of 16).
REQ-002 SHALL have local constant LIMBS = WIDTH/16, and local constant STEPS = LIMBS*LIMBS.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode are presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
REQ-008 SHALL have port dataa  input  WIDTH  multiplicand.
REQ-009 SHALL have port datab  input  WIDTH  multiplier.
REQ-010 SHALL have port out_valid  output  1  result is valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  2*WIDTH  product.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, FIX, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; accept occurs on a rising edge with in_valid&in_ready.
REQ-015 On accept, SHALL register |dataa| and |datab| as WIDTH-bit unsigned magnitudes when is_signed=1, raw values otherwise.
REQ-016 On accept, SHALL register neg = is_signed & (dataa[MSB] ^ datab[MSB]), clear the 2*WIDTH accumulator and the step counter, and enter MUL.
REQ-017 The magnitude of -2^(WIDTH-1) SHALL be 2^(WIDTH-1) as an unsigned value, with no overflow.
REQ-018 In MUL, step s SHALL select a-limb i = s mod LIMBS and b-limb j = s div LIMBS, drive both into one 16x16 unsigned multiplier, and add its 32-bit product, shifted left by 16*(i+j), into the accumulator.
REQ-019 MUL SHALL last exactly STEPS cycles; on the last step the FSM SHALL enter FIX.
REQ-020 FIX SHALL load result with the two's-complement negation of the accumulator if neg, else with the accumulator.
REQ-021 FIX SHALL set out_valid=1 and enter DONE.
REQ-022 Latency SHALL be STEPS+1 cycles from the accept edge to the edge that raises out_valid (5 for WIDTH=32).
REQ-023 In DONE, result and out_valid SHALL hold stable until out_ready=1 on a rising edge.
REQ-024 On the out_ready=1 edge in DONE, the block SHALL clear out_valid and enter IDLE.
REQ-025 Minimum initiation interval SHALL be STEPS+3 cycles; there SHALL be no accept in the DONE cycle.
REQ-026 in_valid in non-IDLE states SHALL be ignored, and input changes after accept SHALL NOT affect the result.
REQ-027 out_ready outside DONE SHALL have no effect.
REQ-028 Accumulation SHALL be exact modulo 2^(2*WIDTH); the final product SHALL never need truncation.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, accumulator=0, step counter=0, neg=0.
REQ-030 Reset asserted mid-operation (MUL/FIX/DONE) SHALL abort the operation with no result delivered.
REQ-031 Release of reset SHALL be usable with an accept on the first following rising edge.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding and the limb width constant (16).
REQ-033 The 16x16 unsigned combinational multiplier SHALL be the existing mult16 sub-module, instantiated exactly once.
REQ-034 All other logic (limb muxing, shifting, accumulation, sign handling) SHALL be in mult_iter.

Verification (WIDTH=32 unless noted)
REQ-035 Bench SHALL check: unsigned 0xFFFFFFFF * 0xFFFFFFFF -> result 0xFFFFFFFE00000001, out_valid exactly 5 edges after accept.
REQ-036 Bench SHALL check: signed 0xFFFFFFFD * 0x00000005 (-3*5) -> 0xFFFFFFFFFFFFFFF1.
REQ-037 Bench SHALL check: signed 0x80000000 * 0x80000000 -> 0x4000000000000000; unsigned same operands -> 0x4000000000000000.
REQ-038 Bench SHALL check: out_ready held low 10 cycles after out_valid -> result stable, in_ready=0; a new in_valid during the stall is ignored; after out_ready the next accept yields its own correct product.
REQ-039 Bench SHALL check: reset_n pulsed low during MUL step 2 -> out_valid stays 0, in_ready=1 immediately, and the next operation 0x1234*0x5678 -> 0x06260060.
REQ-040 Bench SHALL check: WIDTH=64 random signed/unsigned pairs vs. reference model, with latency 17.
